// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared constants, state encodings and helpers for the
// serial configuration receiver.
//   HDR_BYTE      - frame start marker
//   BCAST_GA      - geographic address that every board accepts
//   rx_state_e    - byte receiver (8N1 deserialiser) states
//   parse_state_e - frame parser states
//   ga_match()    - address filter (own slot or broadcast)
package uart_cfg_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hAA;
  localparam logic [4:0] BCAST_GA = 5'h1F;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    PS_HDR,
    PS_ADDR,
    PS_IDX,
    PS_DATA,
    PS_CKS
  } parse_state_e;

  // ADDR[7:5] is deliberately not an argument: only the slot field matters.
  function automatic logic ga_match(input logic [4:0] addr, input logic [4:0] ga);
    return (addr == ga) || (addr == BCAST_GA);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   rxb      in   asynchronous serial line (idle high, LSB first)
//   rx_data  out  received byte, valid while rx_vld is high
//   rx_vld   out  one-cycle strobe, cycle after a high stop-bit sample
//   rx_fe    out  one-cycle strobe, cycle after a low stop-bit sample
// The line is synchronised by two flops; a falling edge seen in IDLE starts
// the bit timer, the start bit is re-checked half a bit later, and every
// following bit is sampled one full bit period after the previous sample.
module uart_rx_byte
  import uart_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxb,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_fe
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          vld_q, vld_d;
  logic          fe_q, fe_d;

  // Synchroniser chain plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxb;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= {CW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      fe_q    <= fe_d;
    end
  end

  // Bit timing, deserialisation and stop-bit decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = {CW{1'b0}};
          bit_d = 3'd0;
          // A start bit that is already high again was only a glitch.
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = {CW{1'b0}};
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Re-arm at the stop-bit centre so a back-to-back start edge is seen.
          state_d = RX_IDLE;
          if (sync2_q) begin
            data_d = shift_q;
            vld_d  = 1'b1;
          end else begin
            fe_d   = 1'b1;
          end
        end else begin
          state_d = RX_STOP;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_data = data_q;
  assign rx_vld  = vld_q;
  assign rx_fe   = fe_q;

endmodule

// File: rtl/uart_cfg_rx.sv
// uart_cfg_rx: addressed configuration-frame receiver and register bank.
// Frame: 0xAA, ADDR, IDX, REG_W/8 data bytes (MSB first), CKS = XOR of
// ADDR, IDX and data bytes.
//   I_clk_10M  in   sole clock
//   I_rst      in   synchronous active-high reset
//   I_rxb      in   asynchronous UART line
//   I_GA       in   geographic address of this board
//   O_regs     out  register bank, register k at [k*REG_W +: REG_W]
//   O_upd_vld  out  one-cycle pulse when a register is written
//   O_upd_idx  out  index of the written register
//   O_fe       out  one-cycle pulse on a low stop bit (frame aborted)
//   O_cks_err  out  one-cycle pulse on a checksum mismatch
module uart_cfg_rx
  import uart_cfg_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 87,
  parameter  int NUM_REGS     = 3,
  parameter  int REG_W        = 32,
  parameter  int TIMEOUT_CLKS = 20000,
  localparam int IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      I_clk_10M,
  input  logic                      I_rst,
  input  logic                      I_rxb,
  input  logic [4:0]                I_GA,
  output logic [NUM_REGS*REG_W-1:0] O_regs,
  output logic                      O_upd_vld,
  output logic [IDX_W-1:0]          O_upd_idx,
  output logic                      O_fe,
  output logic                      O_cks_err
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]    NB_LAST  = 4'(REG_W / 8 - 1);

  logic [7:0] rx_data;
  logic       rx_vld, rx_fe;

  parse_state_e                      state_q, state_d;
  logic [4:0]                        addr_q, addr_d;
  logic [7:0]                        idx_q, idx_d;
  logic [7:0]                        xor_q, xor_d;
  logic [REG_W-1:0]                  stage_q, stage_d;
  logic [3:0]                        bcnt_q, bcnt_d;
  logic [TW-1:0]                     tmo_q, tmo_d;
  logic [NUM_REGS-1:0][REG_W-1:0]    regs_q, regs_d;
  logic                              upd_vld_q, upd_vld_d;
  logic [IDX_W-1:0]                  upd_idx_q, upd_idx_d;
  logic                              cks_err_q, cks_err_d;
  logic                              timeout_s;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk    (I_clk_10M),
    .rst    (I_rst),
    .rxb    (I_rxb),
    .rx_data(rx_data),
    .rx_vld (rx_vld),
    .rx_fe  (rx_fe)
  );

  // Parser, staging, timeout and register-bank registers.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      state_q   <= PS_HDR;
      addr_q    <= 5'd0;
      idx_q     <= 8'd0;
      xor_q     <= 8'd0;
      stage_q   <= {REG_W{1'b0}};
      bcnt_q    <= 4'd0;
      tmo_q     <= {TW{1'b0}};
      regs_q    <= {(NUM_REGS*REG_W){1'b0}};
      upd_vld_q <= 1'b0;
      upd_idx_q <= {IDX_W{1'b0}};
      cks_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      stage_q   <= stage_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      regs_q    <= regs_d;
      upd_vld_q <= upd_vld_d;
      upd_idx_q <= upd_idx_d;
      cks_err_q <= cks_err_d;
    end
  end

  // Inter-byte timeout: a byte strobe in the same cycle wins and reloads.
  always_comb begin
    if ((state_q == PS_HDR) || rx_vld) begin
      tmo_d = {TW{1'b0}};
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
    timeout_s = (state_q != PS_HDR) && !rx_vld && (tmo_q == TMO_LAST);
  end

  // Frame parser: next state, running checksum, staging and bank write.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    stage_d   = stage_q;
    bcnt_d    = bcnt_q;
    regs_d    = regs_q;
    upd_vld_d = 1'b0;
    upd_idx_d = upd_idx_q;
    cks_err_d = 1'b0;
    if (rx_fe) begin
      state_d = PS_HDR;
    end else if (rx_vld) begin
      case (state_q)
        PS_HDR: begin
          if (rx_data == HDR_BYTE) begin
            state_d = PS_ADDR;
            xor_d   = 8'h00;
          end else begin
            state_d = PS_HDR;
          end
        end
        PS_ADDR: begin
          addr_d  = rx_data[4:0];
          xor_d   = xor_q ^ rx_data;
          state_d = PS_IDX;
        end
        PS_IDX: begin
          idx_d   = rx_data;
          xor_d   = xor_q ^ rx_data;
          bcnt_d  = 4'd0;
          state_d = PS_DATA;
        end
        PS_DATA: begin
          xor_d   = xor_q ^ rx_data;
          stage_d = (stage_q << 8) | REG_W'(rx_data);
          bcnt_d  = bcnt_q + 4'd1;
          if (bcnt_q == NB_LAST) begin
            state_d = PS_CKS;
          end else begin
            state_d = PS_DATA;
          end
        end
        PS_CKS: begin
          state_d = PS_HDR;
          if (rx_data != xor_q) begin
            cks_err_d = 1'b1;
          end else if (ga_match(addr_q, I_GA) && (idx_q < 8'(NUM_REGS))) begin
            upd_vld_d = 1'b1;
            upd_idx_d = idx_q[IDX_W-1:0];
            for (int k = 0; k < NUM_REGS; k++) begin
              if (idx_q == 8'(k)) begin
                regs_d[k] = stage_q;
              end else begin
                regs_d[k] = regs_q[k];
              end
            end
          end else begin
            // Valid checksum but not for us, or no such register: drop quietly.
            upd_vld_d = 1'b0;
          end
        end
        default: begin
          state_d = PS_HDR;
        end
      endcase
    end else if (timeout_s) begin
      state_d = PS_HDR;
    end else begin
      state_d = state_q;
    end
  end

  assign O_regs    = regs_q;
  assign O_upd_vld = upd_vld_q;
  assign O_upd_idx = upd_idx_q;
  assign O_fe      = rx_fe;
  assign O_cks_err = cks_err_q;

endmodule

// File: tb/tb_uart_cfg_rx.sv
// Scoreboard bench for uart_cfg_rx: two instances (3x32 and 8x16 banks).
// Expected events come from a frame-level reference model and are queued
// when a frame is issued; per-instance monitors pop and compare on strobes.
module tb_uart_cfg_rx;

  localparam int CPB = 12;
  localparam int TMO = 400;
  localparam int NR0 = 3;
  localparam int RW0 = 32;
  localparam int NR1 = 8;
  localparam int RW1 = 16;
  localparam logic [4:0] GA = 5'd3;

  logic clk = 1'b0;
  logic rst;
  logic rxb0, rxb1;
  logic [NR0*RW0-1:0] regs0;
  logic [NR1*RW1-1:0] regs1;
  logic upd0, fe0, ce0, upd1, fe1, ce1;
  logic [1:0] idx0;
  logic [2:0] idx1;

  always #5 clk = ~clk;

  uart_cfg_rx #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR0), .REG_W(RW0), .TIMEOUT_CLKS(TMO)) dut0 (
    .I_clk_10M(clk), .I_rst(rst), .I_rxb(rxb0), .I_GA(GA), .O_regs(regs0),
    .O_upd_vld(upd0), .O_upd_idx(idx0), .O_fe(fe0), .O_cks_err(ce0));

  uart_cfg_rx #(.CLKS_PER_BIT(CPB), .NUM_REGS(NR1), .REG_W(RW1), .TIMEOUT_CLKS(TMO)) dut1 (
    .I_clk_10M(clk), .I_rst(rst), .I_rxb(rxb1), .I_GA(GA), .O_regs(regs1),
    .O_upd_vld(upd1), .O_upd_idx(idx1), .O_fe(fe1), .O_cks_err(ce1));

  // Event kinds: 0 register update, 1 framing error, 2 checksum error.
  typedef struct {
    int           kind;
    int           idx;
    logic [127:0] regs;
  } evt_t;

  evt_t         q0[$];
  evt_t         q1[$];
  logic [127:0] model[2];
  logic [7:0]   fr[$];
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic monitor(input int w, input logic u, input logic f, input logic c,
                         input int idx, input logic [127:0] regs);
    evt_t e;
    int   kind;
    check("strobe_onehot", 128'(int'(u) + int'(f) + int'(c)), 128'd1);
    kind = u ? 0 : (f ? 1 : 2);
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event dut%0d: got kind %0d idx %0d, required no event", w, kind, idx);
    end else begin
      if (w == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check("evt_kind", 128'(kind), 128'(e.kind));
      if (e.kind == 0) check("upd_idx", 128'(idx), 128'(e.idx));
      check("evt_regs", regs, e.regs);
    end
  endtask

  always @(negedge clk) if (upd0 || fe0 || ce0) monitor(0, upd0, fe0, ce0, int'(idx0), {32'd0, regs0});
  always @(negedge clk) if (upd1 || fe1 || ce1) monitor(1, upd1, fe1, ce1, int'(idx1), regs1);

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_evt(input int w, input int kind, input int idx);
    evt_t e;
    e.kind = kind;
    e.idx  = idx;
    e.regs = model[w];
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Build a frame in fr; cks_flip corrupts the checksum when non-zero.
  task automatic build(input int w, input logic [7:0] addr, input logic [7:0] idx,
                       input logic [63:0] data, input logic [7:0] cks_flip);
    int nb;
    logic [7:0] x;
    nb = (w == 0) ? RW0 / 8 : RW1 / 8;
    fr.delete();
    fr.push_back(8'hAA);
    fr.push_back(addr);
    fr.push_back(idx);
    for (int i = nb - 1; i >= 0; i--) fr.push_back(data[i*8 +: 8]);
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x ^= fr[i];
    fr.push_back(x ^ cks_flip);
  endtask

  // Reference model: outcome of the complete frame held in fr.
  task automatic expect_frame(input int w);
    int n, nr, rw, ix;
    logic [7:0] x, a;
    logic [127:0] data, mask;
    n  = fr.size();
    nr = (w == 0) ? NR0 : NR1;
    rw = (w == 0) ? RW0 : RW1;
    x  = 8'h00;
    data = 128'd0;
    for (int i = 1; i < n - 1; i++) x ^= fr[i];
    for (int i = 3; i < n - 1; i++) data = (data << 8) | 128'(fr[i]);
    a  = fr[1];
    ix = int'(fr[2]);
    if (x != fr[n-1]) begin
      push_evt(w, 2, 0);
    end else if ((a[4:0] == GA || a[4:0] == 5'h1F) && ix < nr) begin
      mask = ((128'd1 << rw) - 128'd1) << (ix * rw);
      model[w] = (model[w] & ~mask) | (data << (ix * rw));
      push_evt(w, 0, ix);
    end
  endtask

  task automatic send_bit(input int w, input logic v);
    if (w == 0) rxb0 = v;
    else        rxb1 = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input int w, input logic [7:0] b, input logic stop);
    send_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(w, b[i]);
    send_bit(w, stop);
    if (!stop) send_bit(w, 1'b1);
  endtask

  task automatic send_frame(input int w, input int first, input int last,
                            input int fe_pos, input int gap_max);
    for (int i = first; i <= last; i++) begin
      send_byte(w, fr[i], i != fe_pos);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic drain(input int w);
    repeat (4) @(negedge clk);
    if (w == 0) begin
      check("drain0", 128'(q0.size()), 128'd0);
      check("bank0", {32'd0, regs0}, model[0]);
    end else begin
      check("drain1", 128'(q1.size()), 128'd0);
      check("bank1", regs1, model[1]);
    end
  endtask

  task automatic full_frame(input int w, input int gap_max);
    expect_frame(w);
    send_frame(w, 0, fr.size() - 1, -1, gap_max);
    drain(w);
  endtask

  task automatic random_frames(input int w, input int n);
    int nr;
    nr = (w == 0) ? NR0 : NR1;
    for (int k = 0; k < n; k++) begin
      logic [4:0] lo;
      logic [7:0] flip;
      case ($urandom_range(0, 2))
        0:       lo = GA;
        1:       lo = 5'h1F;
        default: lo = 5'h0A;
      endcase
      flip = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build(w, {3'($urandom_range(0, 7)), lo}, 8'($urandom_range(0, nr)),
            {$urandom, $urandom}, flip);
      full_frame(w, 30);
    end
  endtask

  initial begin
    rst = 1'b1;
    rxb0 = 1'b1;
    rxb1 = 1'b1;
    model[0] = 128'd0;
    model[1] = 128'd0;
    repeat (5) @(negedge clk);
    check("reset_regs0", {32'd0, regs0}, 128'd0);
    check("reset_regs1", regs1, 128'd0);
    check("reset_strobes", 128'({upd0, fe0, ce0, upd1, fe1, ce1}), 128'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Own-address write to register 1.
    build(0, 8'h03, 8'h01, 64'h0000_1234, 8'h00);
    full_frame(0, 0);
    check("t1_reg1", 128'(regs0[63:32]), 128'h1234);
    check("t1_others", 128'({regs0[95:64], regs0[31:0]}), 128'd0);

    // Broadcast accepted; foreign address dropped silently.
    build(0, 8'h1F, 8'h02, 64'hDEAD_BEEF, 8'h00);
    full_frame(0, 5);
    check("t2_reg2", 128'(regs0[95:64]), 128'hDEAD_BEEF);
    build(0, 8'h05, 8'h02, 64'h0BAD_0BAD, 8'h00);
    full_frame(0, 5);

    // Checksum error, then a good frame.
    build(0, 8'h03, 8'h01, 64'h0000_1234, 8'hFF);
    full_frame(0, 0);
    build(0, 8'hE3, 8'h00, 64'hCAFE_F00D, 8'h00);
    full_frame(0, 0);

    // Framing error on the IDX byte aborts the frame.
    build(0, 8'h03, 8'h01, 64'h1111_2222, 8'h00);
    push_evt(0, 1, 0);
    send_frame(0, 0, 2, 2, 0);
    drain(0);
    build(0, 8'h03, 8'h01, 64'h3333_4444, 8'h00);
    full_frame(0, 0);

    // Short low glitch on the idle line produces nothing.
    rxb0 = 1'b0;
    repeat (3) @(negedge clk);
    rxb0 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    drain(0);

    // Timeout after a partial frame; next frame must parse cleanly.
    build(0, 8'h03, 8'h01, 64'h5555_6666, 8'h00);
    send_frame(0, 0, 2, -1, 0);
    repeat (TMO + 10) @(negedge clk);
    drain(0);
    build(0, 8'h03, 8'h01, 64'h7777_8888, 8'h00);
    full_frame(0, 0);

    // Out-of-range index dropped.
    build(0, 8'h03, 8'h03, 64'h9999_9999, 8'h00);
    full_frame(0, 0);

    random_frames(0, 20);

    // Reset between DATA bytes; remaining bytes must not update anything.
    build(0, 8'h03, 8'h00, 64'h1122_3344, 8'h00);
    send_frame(0, 0, 3, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_regs0", {32'd0, regs0}, 128'd0);
    check("midrst_strobes", 128'({upd0, fe0, ce0, upd1, fe1, ce1}), 128'd0);
    rst = 1'b0;
    model[0] = 128'd0;
    model[1] = 128'd0;
    send_frame(0, 4, fr.size() - 1, -1, 0);
    drain(0);

    // 8 x 16 instance: IDX 8 dropped, IDX 7 writes the top slice.
    build(1, 8'h03, 8'h08, 64'h0000_1234, 8'h00);
    full_frame(1, 0);
    build(1, 8'h03, 8'h07, 64'h0000_BEEF, 8'h00);
    full_frame(1, 0);
    check("t6_idx7", 128'(regs1[127:112]), 128'hBEEF);
    random_frames(1, 15);

    drain(0);
    drain(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
